dcache_port: RTL and testbench

Sequential request/response adapter between the MEM stage and the data cache. It turns the MEM stage's level-held load/store request into a single dcache transaction with a stall handshake. It also aligns store data into byte lanes, registers the returned load word for MEM-stage extraction, flags misaligned accesses, and keeps load/store/stall performance counters.

---
 rtl/dcache_port_pkg.sv | 20 ++
 rtl/dcache_port_store_align.sv | 21 ++
 rtl/dcache_port.sv | 115 +++++++++++
 tb/tb_dcache_port.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_port_pkg.sv
// Shared types for the MEM-stage dcache port: access size encoding and the
// port FSM state constants, visible to the hazard unit as well.
package dcache_port_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } mem_size_t;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    // Halfwords need bit 0 clear, words need both low bits clear.
    function automatic logic addr_misaligned(input mem_size_t size, input logic [1:0] offset);
        return ((size == SZ_H) && offset[0]) || ((size == SZ_W) && (offset != 2'b00));
    endfunction

endpackage

// File: rtl/dcache_port_store_align.sv
// Combinational store-data lane shifter: moves byte/halfword data into the
// byte lanes selected by the low address bits.
module store_align
    import dcache_port_pkg::*;
(
    input  logic [31:0] wdata_i,
    input  mem_size_t   size_i,
    input  logic [1:0]  offset_i,
    output logic [31:0] wdata_o
);

    always_comb begin
        wdata_o = wdata_i;
        case (size_i)
            SZ_B:    wdata_o = wdata_i << {offset_i, 3'b000};
            SZ_H:    wdata_o = wdata_i << {offset_i[1], 4'b0000};
            default: wdata_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/dcache_port.sv
// MEM-stage to dcache adapter: turns a level-held load/store into one dcache
// transaction with a stall handshake, registers load data, counts activity.
module dcache_port
    import dcache_port_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [31:0]      mem_addr,
    input  logic [1:0]       mem_size,
    input  logic [31:0]      mem_wdata,
    input  logic [3:0]       mem_byte_enable,
    input  logic             hold_in,
    output logic             stall_out,
    output logic [31:0]      port_rdata,
    output logic             misaligned,
    output logic             dcache_read,
    output logic             dcache_write,
    output logic [31:0]      dcache_address,
    output logic [3:0]       dcache_mbe,
    output logic [31:0]      dcache_wdata,
    input  logic [31:0]      dcache_rdata,
    input  logic             dcache_resp,
    output logic [CNT_W-1:0] load_count,
    output logic [CNT_W-1:0] store_count,
    output logic [CNT_W-1:0] stall_cycles
);

    logic [1:0]       state_q, state_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [CNT_W-1:0] load_q, load_d;
    logic [CNT_W-1:0] store_q, store_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic      access;
    logic      mis;
    logic      req;
    logic      issue;
    logic      xfer_done;
    mem_size_t size;

    assign size      = mem_size_t'(mem_size);
    assign access    = mem_read | mem_write;
    assign mis       = access & addr_misaligned(size, mem_addr[1:0]);
    assign req       = access & ~mis;
    // BUSY keeps the strobes up on its own; DONE never issues, so a request
    // still held by a stalled pipeline cannot be replayed.
    assign issue     = ((state_q == ST_IDLE) & req) | (state_q == ST_BUSY);
    assign xfer_done = issue & dcache_resp;

    assign stall_out      = issue;
    assign misaligned     = mis;
    assign dcache_read    = issue & mem_read;
    assign dcache_write   = issue & mem_write & ~mem_read;
    assign dcache_address = {mem_addr[31:2], 2'b00};
    assign dcache_mbe     = issue ? mem_byte_enable : 4'b0000;
    assign port_rdata     = rdata_q;
    assign load_count     = load_q;
    assign store_count    = store_q;
    assign stall_cycles   = stall_q;

    store_align u_store_align (
        .wdata_i  (mem_wdata),
        .size_i   (size),
        .offset_i (mem_addr[1:0]),
        .wdata_o  (dcache_wdata)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req) state_d = dcache_resp ? ST_DONE : ST_BUSY;
            ST_BUSY: if (dcache_resp) state_d = ST_DONE;
            ST_DONE: if (!hold_in) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        load_d  = load_q;
        store_d = store_q;
        stall_d = stall_q;
        if (xfer_done && mem_read) begin
            rdata_d = dcache_rdata;
            load_d  = load_q + CNT_W'(1);
        end
        if (xfer_done && !mem_read) begin
            store_d = store_q + CNT_W'(1);
        end
        if (issue) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rdata_q <= '0;
            load_q  <= '0;
            store_q <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            load_q  <= load_d;
            store_q <= store_d;
            stall_q <= stall_d;
        end
    end

endmodule

// File: tb/tb_dcache_port.sv
// Self-checking bench for dcache_port: table of transactions, a scoreboard of
// expected dcache requests, and hand-written reset / back-to-back sequences.
module tb_dcache_port;
    import dcache_port_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr;
    logic [1:0]  mem_size;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic        hold_in;
    logic        stall_out;
    logic [31:0] port_rdata;
    logic        misaligned;
    logic        dcache_read, dcache_write;
    logic [31:0] dcache_address;
    logic [3:0]  dcache_mbe;
    logic [31:0] dcache_wdata;
    logic [31:0] dcache_rdata;
    logic        dcache_resp;
    logic [31:0] load_count, store_count, stall_cycles;

    always #5 clk = ~clk;

    dcache_port #(.CNT_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_addr        (mem_addr),
        .mem_size        (mem_size),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .hold_in         (hold_in),
        .stall_out       (stall_out),
        .port_rdata      (port_rdata),
        .misaligned      (misaligned),
        .dcache_read     (dcache_read),
        .dcache_write    (dcache_write),
        .dcache_address  (dcache_address),
        .dcache_mbe      (dcache_mbe),
        .dcache_wdata    (dcache_wdata),
        .dcache_rdata    (dcache_rdata),
        .dcache_resp     (dcache_resp),
        .load_count      (load_count),
        .store_count     (store_count),
        .stall_cycles    (stall_cycles)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } txn_t;

    txn_t sb_q[$];
    txn_t mon_t;
    int   reads_seen = 0;

    // Scoreboard: each completed dcache request must match the oldest expected one.
    always @(negedge clk) begin
        if (!rst && dcache_resp && (dcache_read || dcache_write)) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got request addr 0x%08h expected none", dcache_address);
            end else begin
                mon_t = sb_q.pop_front();
                chk("sb_read", 32'(dcache_read), 32'(mon_t.rd));
                chk("sb_write", 32'(dcache_write), 32'(mon_t.wr));
                chk("sb_addr", dcache_address, mon_t.addr);
                chk("sb_mbe", 32'(dcache_mbe), 32'(mon_t.be));
                if (mon_t.wr) chk("sb_wdata", dcache_wdata, mon_t.wdata);
                if (dcache_read) reads_seen++;
            end
        end
    end

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        mem_size_t   size;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        int          lat;
        int          hold;
        logic        mis;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t        vecs[12];
    logic [31:0] m_rdata;
    int          m_load, m_store, m_stall;

    task automatic run_vec(input vec_t v, input int idx);
        int   stalls;
        int   rd0;
        txn_t t;
        @(posedge clk); #1;
        mem_read        = v.rd;
        mem_write       = v.wr;
        mem_addr        = v.addr;
        mem_size        = v.size;
        mem_wdata       = v.wdata;
        mem_byte_enable = v.be;
        hold_in         = 1'b0;
        dcache_resp     = 1'b0;
        dcache_rdata    = v.rdata;
        if (v.mis) begin
            for (int c = 0; c < 2; c++) begin
                @(negedge clk);
                chk($sformatf("v%0d_mis_flag", idx), 32'(misaligned), 32'd1);
                chk($sformatf("v%0d_mis_stall", idx), 32'(stall_out), 32'd0);
                chk($sformatf("v%0d_mis_strobes", idx), {30'd0, dcache_read, dcache_write}, 32'd0);
                chk($sformatf("v%0d_mis_mbe", idx), 32'(dcache_mbe), 32'd0);
                @(posedge clk); #1;
            end
            @(negedge clk);
            chk($sformatf("v%0d_mis_loads", idx), load_count, 32'(m_load));
            chk($sformatf("v%0d_mis_stores", idx), store_count, 32'(m_store));
            chk($sformatf("v%0d_mis_stalls", idx), stall_cycles, 32'(m_stall));
            chk($sformatf("v%0d_mis_rdata", idx), port_rdata, m_rdata);
            return;
        end
        t.rd    = v.rd;
        t.wr    = v.wr & ~v.rd;
        t.addr  = {v.addr[31:2], 2'b00};
        t.wdata = v.exp_wdata;
        t.be    = v.be;
        sb_q.push_back(t);
        rd0    = reads_seen;
        stalls = 0;
        for (int k = 1; k <= v.lat; k++) begin
            dcache_resp = (k == v.lat);
            @(negedge clk);
            if (k == 1) chk($sformatf("v%0d_not_mis", idx), 32'(misaligned), 32'd0);
            if (stall_out) stalls++;
            @(posedge clk); #1;
        end
        dcache_resp = 1'b0;
        hold_in     = (v.hold > 0);
        m_stall += v.lat;
        if (v.rd) begin
            m_load++;
            m_rdata = v.rdata;
        end else begin
            m_store++;
        end
        @(negedge clk);
        chk($sformatf("v%0d_stall_len", idx), 32'(stalls), 32'(v.lat));
        chk($sformatf("v%0d_done_stall", idx), 32'(stall_out), 32'd0);
        chk($sformatf("v%0d_done_strobes", idx), {30'd0, dcache_read, dcache_write}, 32'd0);
        chk($sformatf("v%0d_rdata", idx), port_rdata, m_rdata);
        chk($sformatf("v%0d_loads", idx), load_count, 32'(m_load));
        chk($sformatf("v%0d_stores", idx), store_count, 32'(m_store));
        chk($sformatf("v%0d_stalls", idx), stall_cycles, 32'(m_stall));
        for (int h = 1; h <= v.hold; h++) begin
            @(posedge clk); #1;
            hold_in      = (h < v.hold);
            dcache_resp  = (h == 1);
            dcache_rdata = 32'hFFFF_FFFF;
            @(negedge clk);
            chk($sformatf("v%0d_hold%0d_stall", idx, h), 32'(stall_out), 32'd0);
            chk($sformatf("v%0d_hold%0d_strobes", idx, h), {30'd0, dcache_read, dcache_write}, 32'd0);
            chk($sformatf("v%0d_hold%0d_rdata", idx, h), port_rdata, m_rdata);
            chk($sformatf("v%0d_hold%0d_loads", idx, h), load_count, 32'(m_load));
        end
        chk($sformatf("v%0d_read_txns", idx), 32'(reads_seen - rd0), v.rd ? 32'd1 : 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        //                rd    wr    addr          size  wdata          be       rdata          lat hold mis   exp_wdata
        vecs[0]  = '{1'b1, 1'b0, 32'h0000_0100, SZ_W, 32'h0,         4'b1111, 32'hDEAD_BEEF, 1, 0, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 32'h0000_0203, SZ_B, 32'h0000_00AB, 4'b1000, 32'h0,         3, 0, 1'b0, 32'hAB00_0000};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_0101, SZ_H, 32'h0,         4'b0110, 32'h0,         0, 0, 1'b1, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_0300, SZ_W, 32'h0,         4'b1111, 32'h1234_5678, 1, 4, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 1'b1, 32'h0000_0402, SZ_H, 32'h0000_BEEF, 4'b1100, 32'h0,         2, 0, 1'b0, 32'hBEEF_0000};
        vecs[5]  = '{1'b0, 1'b1, 32'h0000_0500, SZ_W, 32'hCAFE_F00D, 4'b1111, 32'h0,         1, 0, 1'b0, 32'hCAFE_F00D};
        vecs[6]  = '{1'b0, 1'b1, 32'h0000_0502, SZ_W, 32'h1111_1111, 4'b1111, 32'h0,         0, 0, 1'b1, 32'h0};
        vecs[7]  = '{1'b0, 1'b1, 32'h0000_0601, SZ_B, 32'h1122_3344, 4'b0010, 32'h0,         2, 0, 1'b0, 32'h2233_4400};
        vecs[8]  = '{1'b1, 1'b0, 32'h0000_0702, SZ_B, 32'h0,         4'b0100, 32'h0BAD_F00D, 4, 0, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 1'b1, 32'h0000_0800, SZ_W, 32'h7777_7777, 4'b1111, 32'h600D_CAFE, 2, 0, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 1'b1, 32'h0000_0901, SZ_H, 32'h2222_2222, 4'b0110, 32'h0,         0, 0, 1'b1, 32'h0};
        vecs[11] = '{1'b1, 1'b0, 32'h0000_0A02, SZ_H, 32'h0,         4'b1100, 32'h89AB_CDEF, 1, 0, 1'b0, 32'h0};

        rst = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_size = 2'b00;
        mem_wdata = '0; mem_byte_enable = '0; hold_in = 1'b0;
        dcache_rdata = '0; dcache_resp = 1'b0;
        m_rdata = '0; m_load = 0; m_store = 0; m_stall = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_stall", 32'(stall_out), 32'd0);
        chk("rst_strobes", {30'd0, dcache_read, dcache_write}, 32'd0);
        chk("rst_rdata", port_rdata, 32'd0);
        chk("rst_loads", load_count, 32'd0);
        chk("rst_stores", store_count, 32'd0);
        chk("rst_stalls", stall_cycles, 32'd0);

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // Reset while a store waits in BUSY, then a stray response.
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b1; mem_addr = 32'h40; mem_size = SZ_W;
        mem_wdata = 32'h0F0F_0F0F; mem_byte_enable = 4'b1111; hold_in = 1'b0; dcache_resp = 1'b0;
        @(negedge clk);
        chk("rb_issue_stall", 32'(stall_out), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rb_busy_write", 32'(dcache_write), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0; mem_write = 1'b0; dcache_resp = 1'b1; dcache_rdata = 32'hBAD0_BAD0;
        m_rdata = '0; m_load = 0; m_store = 0; m_stall = 0;
        @(negedge clk);
        chk("rb_strobes", {30'd0, dcache_read, dcache_write}, 32'd0);
        chk("rb_stall", 32'(stall_out), 32'd0);
        @(posedge clk); #1;
        dcache_resp = 1'b0;
        @(negedge clk);
        chk("rb_stalls", stall_cycles, 32'd0);
        chk("rb_stores", store_count, 32'd0);
        chk("rb_rdata", port_rdata, 32'd0);

        // Back-to-back lw / sw, two-cycle latency each.
        base = m_stall;
        run_vec('{1'b1, 1'b0, 32'h10, SZ_W, 32'h0, 4'b1111, 32'h55AA_55AA, 2, 0, 1'b0, 32'h0}, 100);
        run_vec('{1'b0, 1'b1, 32'h14, SZ_W, 32'h0102_0304, 4'b1111, 32'h0, 2, 0, 1'b0, 32'h0102_0304}, 101);
        chk("b2b_stall_cycles", stall_cycles - 32'(base), 32'd4);

        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
        repeat (2) @(posedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
